// File: rtl/ng_pkg.sv
// Shared definitions for the ng instruction-fetch unit: FSM states and default sizes.
package ng_pkg;

    localparam int NG_ADDR_W      = 16;
    localparam int NG_INSTR_W     = 16;
    localparam int NG_STACK_DEPTH = 8;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ng_ret_stack.sv
// Return-address stack: push/pop with full/empty status; top is the most recent push.
module ng_ret_stack #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic [DATA_W-1:0] top_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    cnt_q;
    logic [PTR_W:0]    cnt_d;
    logic [PTR_W-1:0]  top_idx;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign top_idx = PTR_W'(cnt_q - CNT_ONE);
    assign top_o   = mem_q[top_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (do_pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[cnt_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/ng_fetch.sv
// Single-outstanding instruction fetch unit: request, wait for data, offer to decoder,
// then redirect via jump/call/return or flush.
module ng_fetch
    import ng_pkg::*;
#(
    parameter int                ADDR_W      = NG_ADDR_W,
    parameter int                INSTR_W     = NG_INSTR_W,
    parameter int                STACK_DEPTH = NG_STACK_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               jmp,
    input  logic               call,
    input  logic               ret,
    input  logic [ADDR_W-1:0]  target,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr,
    output logic               stk_full,
    output logic               stk_empty,
    output logic               stk_ovf,
    output logic               stk_unf
);
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic               kill_q, kill_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               stk_push;
    logic               stk_pop;
    logic [ADDR_W-1:0]  stk_top;
    logic [ADDR_W-1:0]  seq_pc;
    logic               req_fire;

    assign seq_pc    = ipc_q + PC_ONE;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign instr_pc  = ipc_q;
    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;

    ng_ret_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i (seq_pc),
        .top_o       (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        kill_d   = kill_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        // Request is a function of registers only, so no memory/decoder input reaches it.
        imem_req_valid = (state_q == REQ) && !kill_q;
        instr_valid    = (state_q == OUT);
        req_fire       = imem_req_valid && imem_req_ready;

        if (kill_q && imem_rsp_valid) begin
            kill_d = 1'b0;
        end

        unique case (state_q)
            REQ: begin
                if (req_fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    ipc_d   = pc_q;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (instr_ready) begin
                    state_d = REQ;
                    if (ret) begin
                        if (stk_empty) begin
                            pc_d  = seq_pc;
                            unf_d = 1'b1;
                        end else begin
                            pc_d    = stk_top;
                            stk_pop = 1'b1;
                        end
                    end else if (call) begin
                        pc_d = target;
                        if (stk_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                        end
                    end else if (jmp) begin
                        pc_d = target;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            default: state_d = REQ;
        endcase

        // Any request the memory has taken but not yet answered must be drained silently.
        if (flush) begin
            state_d  = REQ;
            pc_d     = flush_addr;
            instr_d  = instr_q;
            ipc_d    = ipc_q;
            ovf_d    = ovf_q;
            unf_d    = unf_q;
            stk_push = 1'b0;
            stk_pop  = 1'b0;
            kill_d   = (((state_q == WAIT) || kill_q) && !imem_rsp_valid) || req_fire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_VEC;
            instr_q <= '0;
            ipc_q   <= '0;
            kill_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            kill_q  <= kill_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: tb/tb_ng_fetch.sv
// Self-checking bench for ng_fetch: a 16-bit instance against a control-flow model,
// plus an 8-bit instance for address wrap and decoder back-pressure.
module tb_ng_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [15:0] imem_addr, imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [15:0] instr, instr_pc;
    logic        jmp, call, ret, flush;
    logic [15:0] target, flush_addr;
    logic        stk_full, stk_empty, stk_ovf, stk_unf;

    // 8-bit instance
    logic        req_valid8, rsp_valid8, instr_valid8, instr_ready8, jmp8;
    logic        req_ready8 = 1'b1;
    logic [7:0]  imem_addr8, instr_pc8, target8;
    logic [15:0] rsp_data8, instr8;
    logic        full8, empty8, ovf8, unf8;

    int n_pass  = 0;
    int n_total = 0;
    int mem_lat = 1;
    int cyc     = 0;

    ng_fetch #(.ADDR_W(16), .INSTR_W(16), .STACK_DEPTH(8), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .jmp(jmp), .call(call), .ret(ret), .target(target),
        .flush(flush), .flush_addr(flush_addr),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    ng_fetch #(.ADDR_W(8), .INSTR_W(16), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut8 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid8), .imem_req_ready(req_ready8), .imem_addr(imem_addr8),
        .imem_rsp_valid(rsp_valid8), .imem_rsp_data(rsp_data8),
        .instr_valid(instr_valid8), .instr_ready(instr_ready8), .instr(instr8), .instr_pc(instr_pc8),
        .jmp(jmp8), .call(1'b0), .ret(1'b0), .target(target8),
        .flush(1'b0), .flush_addr(8'h00),
        .stk_full(full8), .stk_empty(empty8), .stk_ovf(ovf8), .stk_unf(unf8)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd3) ^ 16'h5A00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory for the 16-bit instance: in-order responses, mem_lat cycles after acceptance.
    logic [15:0] mq_addr[$];
    int          mq_due[$];
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq_addr.delete();
                mq_due.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_addr);
                mq_due.push_back(cyc + mem_lat);
            end
            @(posedge clk);
            cyc++;
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst && mq_due.size() > 0 && mq_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
        end
    end

    // Memory for the 8-bit instance: always ready, one-cycle latency.
    logic       acc8;
    logic [7:0] acc_addr8;
    initial begin
        rsp_valid8 = 1'b0;
        rsp_data8  = '0;
        forever begin
            @(negedge clk);
            acc8      = !rst && req_valid8 && req_ready8;
            acc_addr8 = imem_addr8;
            @(posedge clk);
            #1;
            rsp_valid8 = acc8 && !rst;
            rsp_data8  = mem_word({8'h00, acc_addr8});
        end
    end

    // Reference model: where fetch must go next, what the held instruction must be,
    // and the return stack as a plain queue.
    logic [15:0] exp_pc, pend_addr, prev_instr, prev_ipc;
    logic [15:0] mstk[$];
    bit          pend_v, prev_stall, prev_hs, m_ovf, m_unf, hs_now;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc = 16'h0000; mstk.delete(); pend_v = 0;
                prev_stall = 0; prev_hs = 0; m_ovf = 0; m_unf = 0;
                continue;
            end
            if (prev_hs) chk("hs_to_req", imem_req_valid, 1);
            if (prev_stall) begin
                chk("stall_valid", instr_valid, 1);
                chk("stall_instr", instr, prev_instr);
                chk("stall_pc", instr_pc, prev_ipc);
            end
            chk("stk_empty", stk_empty, (mstk.size() == 0));
            chk("stk_full", stk_full, (mstk.size() == 8));
            chk("stk_ovf", stk_ovf, m_ovf);
            chk("stk_unf", stk_unf, m_unf);
            if (imem_req_valid && imem_req_ready) begin
                chk("fetch_addr", imem_addr, exp_pc);
                pend_v = 1; pend_addr = imem_addr;
            end
            if (instr_valid) begin
                chk("valid_has_fetch", pend_v, 1);
                if (pend_v) begin
                    chk("instr_pc", instr_pc, pend_addr);
                    chk("instr_data", instr, mem_word(pend_addr));
                end
            end
            hs_now = instr_valid && instr_ready;
            if (flush) begin
                exp_pc = flush_addr;
                pend_v = 0;
            end else if (hs_now) begin
                if (ret) begin
                    if (mstk.size() == 0) begin exp_pc = pend_addr + 16'd1; m_unf = 1; end
                    else exp_pc = mstk.pop_back();
                end else if (call) begin
                    if (mstk.size() == 8) m_ovf = 1;
                    else mstk.push_back(pend_addr + 16'd1);
                    exp_pc = target;
                end else if (jmp) exp_pc = target;
                else exp_pc = pend_addr + 16'd1;
                pend_v = 0;
            end
            prev_stall = instr_valid && !instr_ready && !flush;
            prev_hs    = hs_now && !flush;
            prev_instr = instr;
            prev_ipc   = instr_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_v(input bit use8, input string name);
        int n = 0;
        while (!(use8 ? instr_valid8 : instr_valid) && n < 100) begin
            tick();
            n++;
        end
        chk(name, use8 ? instr_valid8 : instr_valid, 1);
    endtask

    task automatic hs(input bit j, input bit c, input bit r, input logic [15:0] tgt);
        jmp = j; call = c; ret = r; target = tgt; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] held;
    initial begin
        imem_req_ready = 1'b0; instr_ready = 1'b0;
        jmp = 1'b0; call = 1'b0; ret = 1'b0; target = '0;
        flush = 1'b0; flush_addr = '0;
        instr_ready8 = 1'b0; jmp8 = 1'b0; target8 = '0;
        repeat (3) tick();
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_empty", stk_empty, 1);
        chk("rst_full", stk_full, 0);
        chk("rst_flags", {stk_ovf, stk_unf}, 0);
        chk("rst_valid8", instr_valid8, 0);
        rst = 1'b0;
        tick();
        chk("req_after_rst", imem_req_valid, 1);
        tick();
        chk("addr_held", imem_addr, 16'h0000);
        imem_req_ready = 1'b1;

        for (int i = 0; i < 5; i++) begin
            wait_v(0, "seq_wait");
            chk("seq_pc", instr_pc, i);
            hs(0, 0, 0, 16'h0000);
        end
        wait_v(0, "jmp_wait");
        hs(1, 0, 0, 16'h0040);
        wait_v(0, "jmp_wait2");
        chk("jmp_target", instr_pc, 16'h0040);
        hs(1, 0, 0, 16'h0010);
        wait_v(0, "call_wait");
        hs(0, 1, 0, 16'h0100);
        wait_v(0, "call_wait2");
        chk("call_target", instr_pc, 16'h0100);
        chk("call_pushed", stk_empty, 0);
        hs(0, 0, 1, 16'h0000);
        wait_v(0, "ret_wait");
        chk("ret_target", instr_pc, 16'h0011);
        chk("ret_empty", stk_empty, 1);

        held = instr;
        repeat (5) tick();
        chk("stall_held", instr, held);
        imem_req_ready = 1'b0;
        hs(0, 0, 0, 16'h0000);
        repeat (3) tick();
        chk("ready_stall_req", imem_req_valid, 1);
        chk("ready_stall_addr", imem_addr, 16'h0012);
        imem_req_ready = 1'b1;

        for (int k = 0; k < 9; k++) begin
            wait_v(0, "deep_call_wait");
            if (k == 8) chk("full_before_9th", stk_full, 1);
            hs(0, 1, 0, 16'h0300 + 16'(k * 16));
        end
        wait_v(0, "ovf_wait");
        chk("ovf_target", instr_pc, 16'h0380);
        chk("ovf_flag", stk_ovf, 1);
        for (int k = 0; k < 8; k++) begin
            wait_v(0, "unwind_wait");
            hs(0, 0, 1, 16'h0000);
        end
        wait_v(0, "unf_wait");
        chk("unwound_pc", instr_pc, 16'h0013);
        hs(0, 0, 1, 16'h0000);
        wait_v(0, "unf_wait2");
        chk("unf_flag", stk_unf, 1);
        chk("unf_pc", instr_pc, 16'h0014);

        mem_lat = 3;
        hs(0, 0, 0, 16'h0000);
        tick();
        chk("in_wait", imem_req_valid, 0);
        flush = 1'b1; flush_addr = 16'h0200;
        tick();
        flush = 1'b0;
        chk("kill_blocks_req", imem_req_valid, 0);
        wait_v(0, "flush_wait");
        chk("flush_pc", instr_pc, 16'h0200);
        chk("flush_data", instr, mem_word(16'h0200));
        mem_lat = 1;

        flush = 1'b1; flush_addr = 16'h0600;
        hs(0, 1, 0, 16'h0500);
        flush = 1'b0;
        wait_v(0, "flush_hs_wait");
        chk("flush_hs_pc", instr_pc, 16'h0600);
        chk("flush_hs_stack", stk_empty, 1);
        flush = 1'b1; flush_addr = 16'h0700;
        tick();
        flush = 1'b0;
        chk("flush_drops_valid", instr_valid, 0);
        wait_v(0, "flush_out_wait");
        chk("flush_out_pc", instr_pc, 16'h0700);

        hs(1, 0, 0, 16'hFFFF);
        wait_v(0, "wrap_wait");
        hs(0, 0, 0, 16'h0000);
        wait_v(0, "wrap_wait2");
        chk("wrap16_pc", instr_pc, 16'h0000);

        wait_v(1, "w8_wait");
        chk("w8_first", instr_pc8, 8'h00);
        jmp8 = 1'b1; target8 = 8'hFF; instr_ready8 = 1'b1;
        tick();
        jmp8 = 1'b0; instr_ready8 = 1'b0;
        wait_v(1, "w8_wait2");
        chk("w8_ff", instr_pc8, 8'hFF);
        instr_ready8 = 1'b1;
        tick();
        instr_ready8 = 1'b0;
        wait_v(1, "w8_wait3");
        chk("w8_wrap_pc", instr_pc8, 8'h00);
        chk("w8_wrap_data", instr8, mem_word(16'h0000));
        repeat (5) tick();
        chk("w8_hold_valid", instr_valid8, 1);
        chk("w8_hold_instr", instr8, mem_word(16'h0000));
        chk("w8_hold_pc", instr_pc8, 8'h00);
        chk("w8_stack_idle", {full8, empty8, ovf8, unf8}, 4'b0100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ng_fetch.md
NG_FETCH -- requirements
Module: ng_fetch

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the program-counter and address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width.
REQ-003 Parameter STACK_DEPTH, default 8, SHALL set the return-stack entry count (power of two, >=2).
REQ-004 Parameter RESET_VEC, default 0, SHALL set the PC value loaded on reset.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 imem_req_valid  out  1  fetch request valid.
REQ-008 imem_req_ready  in  1  memory accepts request.
REQ-009 imem_addr  out  ADDR_W  fetch address.
REQ-010 imem_rsp_valid  in  1  fetch data valid (exactly one response per accepted request, >=1 cycle later).
REQ-011 imem_rsp_data  in  INSTR_W  fetched instruction.
REQ-012 instr_valid  out  1  instruction offered to decoder.
REQ-013 instr_ready  in  1  decoder consumes instruction.
REQ-014 instr  out  INSTR_W  held instruction.
REQ-015 instr_pc  out  ADDR_W  address of held instruction.
REQ-016 jmp, call, ret  in  1 each  control outcome of the consumed instruction; sampled only on instr handshake.
REQ-017 target  in  ADDR_W  jump/call destination; sampled with jmp/call.
REQ-018 flush  in  1  restart fetch at flush_addr; flush_addr  in  ADDR_W.
REQ-019 stk_full, stk_empty  out  1 each  return-stack status; stk_ovf, stk_unf  out  1 each  sticky error flags.

Function
REQ-020 FSM states SHALL be REQ, WAIT, OUT; REQ drives imem_req_valid=1, imem_addr=pc.
REQ-021 REQ->WAIT on imem_req_valid&&imem_req_ready; address held stable until accepted.
REQ-022 WAIT->OUT on imem_rsp_valid: instr<=imem_rsp_data, instr_pc<=pc.
REQ-023 OUT drives instr_valid=1; instr/instr_pc SHALL stay stable until instr_ready.
REQ-024 On instr handshake, next pc SHALL be (priority) ret: stack top (pop); call: target, push instr_pc+1; jmp: target; else instr_pc+1; FSM->REQ.
REQ-025 PC arithmetic SHALL wrap modulo 2^ADDR_W (all-ones +1 = 0).
REQ-026 call when stk_full: push dropped, stk_ovf set, jump to target still taken.
REQ-027 ret when stk_empty: pc<=instr_pc+1, stk_unf set, no pop.
REQ-028 flush SHALL override all: pc<=flush_addr, FSM->REQ next cycle, held instruction discarded, instr_valid low next cycle.
REQ-029 flush in WAIT SHALL set a kill flag so the outstanding response is dropped (no instr_valid) before the new request issues; kill clears on that response.
REQ-030 flush in same cycle as instr handshake: flush wins, stack unchanged.
REQ-031 stk_ovf/stk_unf SHALL remain set until reset.
REQ-032 Minimum latency: request accept to instr_valid = response latency; handshake to next imem_req_valid = 1 cycle.

Reset
REQ-033 While rst=1: pc=RESET_VEC, FSM=REQ, kill=0, stack empty, stk_empty=1, stk_full=0, stk_ovf=stk_unf=0, instr_valid=0, instr=0, instr_pc=0.
REQ-034 imem_req_valid SHALL assert in the first cycle after rst deasserts; reset mid-WAIT abandons the response (memory reset jointly).

Structure
REQ-035 Shared package ng_pkg SHALL hold the FSM state enum and default-width constants.
REQ-036 Return stack SHALL be sub-module ng_ret_stack (push/pop/top/full/empty, depth STACK_DEPTH).
REQ-037 No combinational path from imem_rsp_* or instr_ready to imem_req_valid.

Verification
REQ-038 Reset release, 1-cycle memory -> addresses 0,1,2 fetched; instr_pc matches.
REQ-039 jmp target=0x0040 at instr_pc=0x0005 -> next imem_addr=0x0040.
REQ-040 call 0x0100 at 0x0010, then ret -> fetches 0x0100 then 0x0011; stk_empty returns 1.
REQ-041 9 calls with STACK_DEPTH=8 -> stk_ovf=1, 9th target still fetched; ret on empty -> stk_unf=1, pc=instr_pc+1.
REQ-042 flush 0x0200 during WAIT, response 3 cycles later -> response dropped, next valid instr has instr_pc=0x0200.
REQ-043 ADDR_W=8, pc=0xFF sequential -> next imem_addr=0x00; instr_ready held low 5 cycles -> instr stable.
